// File: rtl/down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : down_timer
//  Description : Programmable down-counting interval timer with one-shot and
//                periodic (auto-reload) modes, pause/resume, a registered
//                one-cycle terminal-count pulse and a sticky done flag.
//  Revision    : 1.0  initial release
// ============================================================================
module down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] reload;
  logic [WIDTH-1:0] reload_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             tc_nxt;
  logic             done_nxt;
  logic             start_ok;

  // A start strobe is honoured from HOLD (resume) or from IDLE with a
  // non-zero interval loaded; a zero interval would expire with no meaning.
  assign start_ok = start &&
                    ((state == S_HOLD) || ((state == S_IDLE) && (count != '0)));

  // Next-state, counter, reload and flag logic; priority load > stop > start.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload;
    done_nxt   = done;
    tc_nxt     = 1'b0;
    if (load) begin
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = S_IDLE;
      done_nxt   = 1'b0;
    end else if (stop) begin
      // Stop masks a simultaneous start; it only acts while running.
      if (state == S_RUN) begin
        state_nxt = S_HOLD;
      end
    end else if (start_ok) begin
      // The start edge itself does not decrement; counting begins next cycle.
      state_nxt = S_RUN;
      done_nxt  = 1'b0;
    end else if (state == S_RUN) begin
      if (count > ONE) begin
        count_nxt = count - ONE;
      end else if (count == ONE) begin
        tc_nxt = 1'b1;
        if (periodic) begin
          count_nxt = reload;
        end else begin
          count_nxt = '0;
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end else begin
        // Unreachable with a zero count; park safely without a pulse.
        state_nxt = S_IDLE;
      end
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      reload <= reload_nxt;
      tc     <= tc_nxt;
      done   <= done_nxt;
    end
  end

  // busy follows the state register directly, so it changes on the same edge.
  assign busy = (state == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_down_timer
//  Description : Self-checking bench for down_timer: directed scenarios plus
//                random stimulus compared against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_down_timer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             periodic = 1'b0;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = idle, 1 = run, 2 = hold.
  int               m_mode = 0;
  logic [WIDTH-1:0] m_cnt  = '0;
  logic [WIDTH-1:0] m_rel  = '0;
  logic             m_tc   = 1'b0;
  logic             m_done = 1'b0;

  down_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .count    (count),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the specification's rules, evaluated on plain integers.
  task automatic model_edge(input bit r, input bit ld, input int lv,
                            input bit st, input bit sp, input bit per);
    int c;
    c = int'(m_cnt);
    m_tc = 1'b0;
    if (r) begin
      m_mode = 0; c = 0; m_rel = '0; m_done = 1'b0;
    end else if (ld) begin
      c = lv; m_rel = WIDTH'(lv); m_mode = 0; m_done = 1'b0;
    end else if (sp) begin
      if (m_mode == 1) m_mode = 2;
    end else if (st && (m_mode == 2 || (m_mode == 0 && c != 0))) begin
      m_mode = 1; m_done = 1'b0;
    end else if (m_mode == 1) begin
      if (c > 1) begin
        c = c - 1;
      end else begin
        m_tc = 1'b1;
        if (per) begin
          c = int'(m_rel);
        end else begin
          c = 0; m_mode = 0; m_done = 1'b1;
        end
      end
    end
    m_cnt = WIDTH'(c);
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs.
  task automatic step(input bit r, input bit ld, input int lv,
                      input bit st, input bit sp, input bit per);
    @(negedge clk);
    rst = r; load = ld; load_val = WIDTH'(lv);
    start = st; stop = sp; periodic = per;
    @(posedge clk);
    model_edge(r, ld, lv, st, sp, per);
    #1;
    chk("count", int'(count), int'(m_cnt));
    chk("tc",    int'(tc),    int'(m_tc));
    chk("busy",  int'(busy),  (m_mode == 1) ? 1 : 0);
    chk("done",  int'(done),  int'(m_done));
  endtask

  task automatic idle(input int n, input bit per);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, per);
  endtask

  initial begin
    int tc_seen;
    int lat;
    bit per_r;

    // Reset held two cycles while load/start toggle.
    step(1, 1, 7, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("rst_count", int'(count), 0);
    chk("rst_busy",  int'(busy),  0);
    // Start with a zero count is ignored.
    step(0, 0, 0, 1, 0, 0);
    chk("zero_start_busy", int'(busy), 0);
    idle(2, 0);

    // One-shot, interval 5.
    step(0, 1, 5, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("os_first", int'(count), 5);
    idle(4, 0);
    chk("os_cnt1", int'(count), 1);
    step(0, 0, 0, 0, 0, 0);
    chk("os_tc", int'(tc), 1);
    chk("os_zero", int'(count), 0);
    chk("os_done", int'(done), 1);
    idle(3, 0);
    chk("os_done_hold", int'(done), 1);

    // Periodic, interval 3, then interval 1.
    step(0, 1, 3, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    tc_seen = 0;
    for (int i = 0; i < 9; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (tc) tc_seen++;
    end
    chk("per3_tcs", tc_seen, 3);
    step(0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    tc_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1);
      if (tc) tc_seen++;
    end
    chk("per1_tcs", tc_seen, 5);
    chk("per1_cnt", int'(count), 1);

    // Pause/resume with interval 6.
    step(0, 1, 6, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(5, 0);
    chk("hold_cnt", int'(count), 4);
    chk("hold_busy", int'(busy), 0);
    step(0, 0, 0, 1, 0, 0);
    idle(4, 0);
    chk("resume_tc", int'(tc), 1);

    // Priority: load+stop+start at count 2 aborts into IDLE with 9.
    step(0, 1, 4, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    idle(2, 0);
    chk("pri_pre", int'(count), 2);
    step(0, 1, 9, 1, 1, 0);
    chk("pri_cnt", int'(count), 9);
    chk("pri_busy", int'(busy), 0);
    // start+stop in RUN goes to HOLD, and stays there.
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("ss_hold", int'(busy), 0);
    chk("ss_cnt", int'(count), 9);
    // Reset at count 1 gives no pulse.
    step(0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst1_pre", int'(count), 1);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst1_tc", int'(tc), 0);

    // Maximum interval, one-shot: pulse 255 edges after the start edge.
    step(0, 1, 255, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    lat = 0;
    for (int i = 0; i < 300 && lat == 0; i++) begin
      step(0, 0, 0, 0, 0, 0);
      if (tc) lat = i + 1;
    end
    chk("max_latency", lat, 255);
    idle(3, 0);
    chk("max_floor", int'(count), 0);
    // Maximum interval, periodic: reload returns to 255.
    step(0, 1, 255, 0, 0, 1);
    step(0, 0, 0, 1, 0, 1);
    idle(255, 1);
    chk("max_reload", int'(count), 255);
    chk("max_per_tc", int'(tc), 1);

    // Random stimulus against the model.
    per_r = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      bit r, ld, st, sp;
      int lv;
      r  = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 19) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) per_r = ~per_r;
      case ($urandom_range(0, 9))
        0:       lv = 0;
        1:       lv = 255;
        2:       lv = 1;
        default: lv = $urandom_range(2, 12);
      endcase
      step(r, ld, lv, st, sp, per_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
